// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty fetch unit.
package bitty_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_MEM,
    ST_ISSUE,
    ST_EXEC,
    ST_HALTED
  } fetch_state_t;

  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/bitty_watchdog.sv
// Clear/enable/expire cycle counter used to bound how long the core may take
// to answer an issued instruction.
module bitty_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // expire is raised during the LIMIT-th enabled cycle, so a same-cycle done
  // can still be honoured by the consumer.
  assign expire = enable && (count == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bitty_fetch_unit.sv
// Bitty instruction fetch/issue unit. Optional EXEC watchdog is compiled in
// when BITTY_FETCH_TIMEOUT_EN is defined.
//
// Core handshake: start is a one-cycle pulse during ISSUE; instruction is held
// stable from ISSUE until the next memory capture. done is a one-cycle pulse
// honoured only in EXEC (never in the start cycle); branch_taken and
// branch_target are sampled in the same cycle as done.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0] HALT_INSTR     = HALT_INSTR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instruction,
  output logic              start,
  input  logic              done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              halted,
  output logic              timeout,
  output fetch_state_t      dbg_state
);

  fetch_state_t state;
  logic         wd_expire;
  logic         timeout_q;

  assign mem_addr  = pc;
  assign dbg_state = state;
  assign timeout   = timeout_q;

`ifdef BITTY_FETCH_TIMEOUT_EN
  bitty_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_ISSUE),
    .enable(state == ST_EXEC),
    .expire(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      start       <= 1'b0;
      retired     <= '0;
      halted      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          // The halt word is never presented to the core.
          if (mem_rdata == HALT_INSTR) begin
            halted <= 1'b1;
            state  <= ST_HALTED;
          end else begin
            instruction <= mem_rdata;
            start       <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (done) begin
            retired <= retired + 1'b1;
            pc      <= branch_taken ? branch_target : pc + 1'b1;
            state   <= run ? ST_FETCH : ST_IDLE;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
            halted    <= 1'b1;
            state     <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bitty_fetch_unit.md
# bitty_fetch_unit

Instruction issue side of the Bitty core handshake: fetches 16-bit instructions from a synchronous-read instruction memory and presents each one to the core with a one-cycle `start` pulse. It then holds the instruction stable until the core returns `done`, and advances the PC, taking a branch redirect if one is reported. It sits between instruction memory and the core and drives the `instruction` bus that the core's completion monitor samples when `done` is asserted.

## Interface
- `ADDR_W`, 8 — PC / memory address width
- `RESET_PC`, 0 — PC value loaded on reset
- `HALT_INSTR`, 16'hFFFF — encoding that stops fetch; never issued
- `TIMEOUT_CYCLES`, 1024 — watchdog limit; used only with `BITTY_FETCH_TIMEOUT_EN`

Ports:
- `clk` in 1 — clock, all logic on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `run` in 1 — enable fetching
- `mem_addr` out ADDR_W — instruction memory address
- `mem_rdata` in 16 — memory data, valid one cycle after `mem_addr`
- `instruction` out 16 — instruction presented to the core
- `start` out 1 — one-cycle issue pulse
- `done` in 1 — core completion, one-cycle pulse
- `branch_taken` in 1 — sampled with `done`
- `branch_target` in ADDR_W — sampled with `done`
- `pc` out ADDR_W — address of the current or next instruction
- `retired` out 16 — count of completed instructions, wraps
- `halted` out 1 — sticky stop flag
- `timeout` out 1 — sticky watchdog flag; tied to 0 when the feature is compiled out

## Operation
- States are IDLE, FETCH, WAIT_MEM, ISSUE, EXEC and HALTED.
- IDLE: go to FETCH when `run`=1.
- FETCH: `mem_addr`=`pc`; always go to WAIT_MEM.
- WAIT_MEM: capture `mem_rdata`.
  - If it equals `HALT_INSTR`, go to HALTED. `halted`=1, `instruction` is unchanged, `pc` is unchanged.
  - Otherwise latch it into `instruction` and go to ISSUE.
- ISSUE: `start`=1 for exactly this cycle; go to EXEC.
- EXEC: wait for `done`. When `done`=1:
  - `retired`++ (wraps from 16'hFFFF to 0).
  - `pc` <= `branch_taken` ? `branch_target` : `pc`+1, computed mod 2^ADDR_W, so `pc` wraps from all-ones to 0.
  - Next state is FETCH if `run`=1, else IDLE.
- HALTED: absorbing state; only reset leaves it.
- `done` is ignored outside EXEC.
- `run` is checked only in IDLE and at EXEC exit. Deasserting `run` mid-instruction lets the current instruction finish.
- `instruction` holds its value from ISSUE until the next WAIT_MEM capture, so it is valid when `done` is sampled.
- `mem_addr` is combinationally equal to `pc` in all states.
- Reset (any state, including EXEC): state=IDLE, `pc`=`RESET_PC`, `instruction`=0, `start`=0, `retired`=0, `halted`=0, `timeout`=0. A pending `done` in the reset cycle is discarded.

## Timing
- FETCH entered at cycle N:
  - `mem_addr` valid at N.
  - `mem_rdata` captured at the end of N+1.
  - `start` high at N+2.
  - `done` accepted from N+3 onward.
- `done` at cycle M: `pc` updated at M+1, FETCH at M+1.
- Minimum issue period is 4 cycles when the core returns `done` in the first EXEC cycle.
- The core must not assert `done` in the same cycle as `start`; that pulse is ignored.

## Configuration
- `BITTY_FETCH_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to EXEC and increments each EXEC cycle.
  - If it reaches `TIMEOUT_CYCLES` without `done`, then `timeout`=1, `halted`=1 and the state goes to HALTED.
  - `done` in the same cycle the limit is reached wins: the instruction retires normally.
- Not defined: EXEC waits indefinitely, `timeout` is constant 0, and no counter is built.

## Structure
- `bitty_pkg` holds the state enum `fetch_state_t` and the default `HALT_INSTR` constant.
- One sub-module, `bitty_watchdog`, provides the clear/enable/expire counter. It is instantiated only under `BITTY_FETCH_TIMEOUT_EN`.

## Test plan
- Reset, `run`=1, memory holds 0x1234, 0x5678, 0xFFFF; core answers `done` 3 cycles after each `start` -> two `start` pulses with `instruction` 0x1234 then 0x5678, `retired`=2, `halted`=1, `pc`=2.
- `done` with `branch_taken`=1, `branch_target`=0x40 -> next `mem_addr`=0x40. With `ADDR_W`=8 and `pc`=0xFF, no branch -> `pc` wraps to 0x00.
- `run` dropped during EXEC -> instruction retires, state IDLE, no further `start`. `run` reasserted -> FETCH the next cycle.
- Spurious `done` in IDLE, FETCH and ISSUE -> `retired` and `pc` unchanged.
- `rst_n`=0 during EXEC with `done` high in the same cycle -> all outputs at reset values and `retired`=0.
- With `BITTY_FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, core never answers -> `timeout`=1 and `halted`=1 exactly 16 EXEC cycles after `start`. `done` on cycle 16 -> retires, `timeout`=0.
